// File: rtl/arb2_pkg.sv
// arb2_pkg: shared types and constants for the two-channel select arbiter.
// Holds the arbiter state encoding, the channel codes (which double as the
// downstream mux select values) and the default grant hold limit.
package arb2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } arb_state_e;

  // Channel codes match the s output: 1 selects the x1 path, 0 the x2 path.
  localparam logic CH1 = 1'b1;
  localparam logic CH2 = 1'b0;

  // Default maximum number of cycles a grant may be held before forced release.
  localparam int TIMEOUT_CYCLES_DEF = 15;

endpackage

// File: rtl/arb2_hold_cnt.sv
// arb2_hold_cnt: 8-bit grant hold counter for the arbiter timeout.
// Clears on clr, counts up while en is high, and flags terminal count when
// the grant has been held for TIMEOUT_CYCLES cycles (count == TIMEOUT_CYCLES-1).
module arb2_hold_cnt #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear wins over enable so a fresh grant always starts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/arb2_sel.sv
// arb2_sel: two-channel arbiter driving the select of a downstream 2:1 mux.
// Every output comes straight from a flop. The select only moves when a new
// grant is issued and holds its value through IDLE so the mux never glitches.
// Optional feature: define ARB2_SEL_TIMEOUT_EN to force release of a grant
// held for TIMEOUT_CYCLES cycles, signalled by a one-cycle tmo pulse.
module arb2_sel
  import arb2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req1,
  input  logic req2,
  input  logic done,
  output logic s,
  output logic gnt1,
  output logic gnt2,
  output logic busy,
  output logic tmo
);

  // The hold counter is 8 bits wide, so the limit must fit in 1..255.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("arb2_sel: TIMEOUT_CYCLES must be in 1..255");
  end

  arb_state_e state_q;
  arb_state_e state_d;
  logic       s_q;
  logic       s_d;
  logic       last_q;
  logic       last_d;
  logic       gnt1_q;
  logic       gnt1_d;
  logic       gnt2_q;
  logic       gnt2_d;
  logic       busy_q;
  logic       busy_d;

`ifdef ARB2_SEL_TIMEOUT_EN
  logic hold_expire;
  logic force_rel;
  logic tmo_q;
  logic tmo_d;

  // Counter clears at every IDLE edge, so it reads zero on the first grant cycle.
  arb2_hold_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == IDLE),
    .en    (state_q != IDLE),
    .tc    (hold_expire)
  );
`endif

  // Next-state logic: arbitrate in IDLE, wait for release in a grant state.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    last_d  = last_q;
`ifdef ARB2_SEL_TIMEOUT_EN
    force_rel = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req1 && (!req2 || last_q == CH2)) begin
          state_d = GNT1;
          s_d     = CH1;
          last_d  = CH1;
        end else if (req2) begin
          state_d = GNT2;
          s_d     = CH2;
          last_d  = CH2;
        end
      end
      GNT1, GNT2: begin
        if (done) begin
          state_d = IDLE;
`ifdef ARB2_SEL_TIMEOUT_EN
        end else if (hold_expire) begin
          state_d   = IDLE;
          force_rel = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the grant flags are registered.
  always_comb begin
    gnt1_d = (state_d == GNT1);
    gnt2_d = (state_d == GNT2);
    busy_d = gnt1_d | gnt2_d;
`ifdef ARB2_SEL_TIMEOUT_EN
    tmo_d  = force_rel;
`endif
  end

  // State and output registers; reset drops any grant at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= CH2;
      last_q  <= CH2;
      gnt1_q  <= 1'b0;
      gnt2_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      last_q  <= last_d;
      gnt1_q  <= gnt1_d;
      gnt2_q  <= gnt2_d;
      busy_q  <= busy_d;
    end
  end

`ifdef ARB2_SEL_TIMEOUT_EN
  // Forced-release pulse register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo = tmo_q;
`else
  assign tmo = 1'b0;
`endif

  assign s    = s_q;
  assign gnt1 = gnt1_q;
  assign gnt2 = gnt2_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_arb2_sel.sv
// tb_arb2_sel: scoreboard bench for arb2_sel.
// The stimulus task advances a cycle-level reference model of the arbitration
// rules and queues the expected outputs; an independent monitor pops and
// compares one entry after every rising edge.
module tb_arb2_sel;

  localparam int TIMEOUT = 4;
`ifdef ARB2_SEL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req1 = 1'b0;
  logic req2 = 1'b0;
  logic done = 1'b0;
  logic s;
  logic gnt1;
  logic gnt2;
  logic busy;
  logic tmo;

  arb2_sel #(
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req1  (req1),
    .req2  (req2),
    .done  (done),
    .s     (s),
    .gnt1  (gnt1),
    .gnt2  (gnt2),
    .busy  (busy),
    .tmo   (tmo)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Expected {s, gnt1, gnt2, busy, tmo} after each rising edge.
  logic [4:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  // Reference model: who owns the mux (0 = nobody), how many cycles the
  // current grant has lasted, which channel was served last, current select.
  int  owner = 0;
  int  held  = 0;
  int  last  = 2;
  int  sel   = 2;
  bit  tmo_m = 1'b0;

  // Drive one cycle of inputs at the falling edge and queue the outcome.
  task automatic applyStimulus(input logic r, input logic a, input logic b, input logic d);
    int winner;
    @(negedge clk);
    rst_n = r;
    req1  = a;
    req2  = b;
    done  = d;
    tmo_m = 1'b0;
    if (!r) begin
      owner = 0;
      held  = 0;
      last  = 2;
      sel   = 2;
    end else if (owner == 0) begin
      winner = 0;
      if (a && b) winner = (last == 1) ? 2 : 1;
      else if (a) winner = 1;
      else if (b) winner = 2;
      if (winner != 0) begin
        owner = winner;
        last  = winner;
        sel   = winner;
        held  = 1;
      end
    end else if (d) begin
      owner = 0;
    end else if (TMO_EN && held >= TIMEOUT) begin
      owner = 0;
      tmo_m = 1'b1;
    end else begin
      held = held + 1;
    end
    exp_q.push_back({(sel == 1), (owner == 1), (owner == 2), (owner != 0), tmo_m});
  endtask

  // Compare the DUT outputs against one scoreboard entry.
  task automatic checkOutput(input logic [4:0] expv);
    logic [4:0] act;
    act = {s, gnt1, gnt2, busy, tmo};
    checks++;
    if (act === expv) begin
      passes++;
    end else begin
      $display("[TB] FAIL outputs at t=%0t {s,gnt1,gnt2,busy,tmo} got=%b expected=%b", $time, act, expv);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge, sampled just after it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    // Reset, then req1 at cycle 2; done at cycle 6 releases the grant.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Both requesting constantly with done always high: alternating grants.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

    // Channel 2 grant, release, then quiet cycles with done toggling in IDLE.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset during a channel 1 grant.
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Channel 2 held without done: timeout release when enabled.
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    // Long channel 1 hold without done.
    repeat (300) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(logic'($urandom_range(0, 39) != 0),
                    logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 3) == 0));
    end

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/arb2_sel.md
ARB2_SEL -- requirements
Module: arb2_sel

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, maximum grant hold in cycles before forced release (range 1..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req1  input  1  channel-1 (x1 path) request; level, held until granted.
REQ-005 req2  input  1  channel-2 (x2 path) request; level, held until granted.
REQ-006 done  input  1  current owner releases the select; sampled only in a grant state.
REQ-007 s  output  1  select for the downstream 2:1 mux; 1 = x1 path, 0 = x2 path.
REQ-008 gnt1  output  1  channel 1 owns the mux.
REQ-009 gnt2  output  1  channel 2 owns the mux.
REQ-010 busy  output  1  high in any grant state.
REQ-011 tmo  output  1  one-cycle pulse on forced release (macro-dependent, see Configuration).

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 FSM states SHALL be IDLE, GNT1, GNT2.
REQ-014 IDLE: req1 only -> GNT1; req2 only -> GNT2; both -> the channel not served last; neither -> stay.
REQ-015 Grant latency SHALL be 1 cycle: request sampled at edge N, gntX and s valid after edge N+1.
REQ-016 GNTx: done=1 -> IDLE next edge; otherwise stay, independent of req levels.
REQ-017 Exactly one IDLE cycle SHALL separate consecutive grants, even with requests pending.
REQ-018 s SHALL change only on IDLE->GNTx transitions and SHALL hold its value through IDLE (no select glitch for the mux).
REQ-019 gnt1 and gnt2 SHALL never be high together; busy = gnt1 | gnt2.
REQ-020 A last-served flag SHALL update on every grant entry; it decides ties only.
REQ-021 done asserted in IDLE SHALL be ignored.

Reset
REQ-022 rst_n=0 at an edge SHALL force IDLE, s=0, gnt1=0, gnt2=0, busy=0, tmo=0, hold counter=0, last-served=channel 2 (channel 1 wins the first tie).
REQ-023 Reset asserted mid-grant SHALL drop the grant at that same edge with no tmo pulse.

Configuration
REQ-024 Macro ARB2_SEL_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on grant entry, increment each cycle in GNTx; when it reaches TIMEOUT_CYCLES-1 with done=0 the FSM SHALL go to IDLE next edge and pulse tmo for that one cycle.
REQ-025 Macro undefined: no counter logic; tmo SHALL be tied 0; grants held indefinitely until done.

Structure
REQ-026 Shared package arb2_pkg SHALL hold the state enum (IDLE/GNT1/GNT2), channel constants CH1=1'b1 / CH2=1'b0 (matching s encoding), and default TIMEOUT_CYCLES.
REQ-027 The hold counter SHALL be a sub-module arb2_hold_cnt (clear, enable, terminal-count out), instantiated only under ARB2_SEL_TIMEOUT_EN.

Verification
REQ-028 Reset then req1=1 at cycle 2 -> gnt1=1, s=1, busy=1 from cycle 3; done=1 at cycle 6 -> gnt1=0 at cycle 7.
REQ-029 req1=req2=1 held constantly, done pulsed each grant -> grants alternate GNT1, GNT2, GNT1 with one IDLE cycle between, s alternating 1,0,1.
REQ-030 Grant to channel 2 (s=0), then done -> s stays 0 through IDLE; no s toggle without a new grant.
REQ-031 rst_n=0 during GNT1 -> all outputs 0, s=0 at that edge; tmo stays 0.
REQ-032 Macro defined, TIMEOUT_CYCLES=4, req2=1, done=0 -> gnt2 high 4 cycles, tmo pulses 1 cycle at release, then IDLE.
REQ-033 Macro undefined, req1=1, done=0 for 300 cycles -> gnt1 stays 1, tmo never 1.
